// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the character-LCD text engine.
//   - HD44780 command bytes used during init and refresh
//   - DDRAM base address of each display row
//   - top-level sequencer states and bus-writer phases
//   - init_cmd(): command byte for each step of the init sequence
package lcd_pkg;

    localparam logic [7:0] LCD_FUNC_SET  = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] LCD_DISP_ON   = 8'h0C;  // display on, cursor off
    localparam logic [7:0] LCD_CLEAR     = 8'h01;
    localparam logic [7:0] LCD_ENTRY     = 8'h06;  // increment address, no shift
    localparam logic [7:0] LCD_SET_DDRAM = 8'h80;

    localparam logic [7:0] LCD_ROW0_BASE = 8'h00;
    localparam logic [7:0] LCD_ROW1_BASE = 8'h40;

    typedef enum logic [2:0] {
        S_PWR  = 3'd0,
        S_INIT = 3'd1,
        S_IDLE = 3'd2,
        S_ADDR = 3'd3,
        S_CHAR = 3'd4
    } lcd_state_e;

    typedef enum logic [1:0] {
        B_IDLE  = 2'd0,
        B_SETUP = 2'd1,
        B_EN    = 2'd2,
        B_WAIT  = 2'd3
    } bus_phase_e;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = LCD_FUNC_SET;
            2'd1:    cmd = LCD_DISP_ON;
            2'd2:    cmd = LCD_CLEAR;
            default: cmd = LCD_ENTRY;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer: performs one HD44780 write transaction per i_start.
// A transaction is 1 setup cycle (EN low, data/RS driven), EN_CYCLES cycles
// with EN high, then a wait of CMD_WAIT_CYCLES (or CLR_WAIT_CYCLES when
// i_long_wait was set at start). Data and RS are held throughout.
// Ports:
//   iCLK, iRST_N      clock, asynchronous active-low reset
//   i_start           begin a transaction; accepted when idle or in the
//                     cycle o_done is high (back-to-back transfers)
//   i_data, i_rs      byte and register select, captured with i_start
//   i_long_wait       use the long post-pulse wait for this transaction
//   o_done            one-cycle pulse in the final wait cycle
//   o_lcd_data/rs/rw/en  LCD bus pins
//
// Handshake: i_start is a single-cycle request that must only be raised
// when the writer is idle or o_done is high; there is no backpressure
// beyond that rule.
module lcd_bus_writer
    import lcd_pkg::*;
#(
    parameter int EN_CYCLES       = 25,
    parameter int CMD_WAIT_CYCLES = 2500,
    parameter int CLR_WAIT_CYCLES = 100000
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       i_start,
    input  logic [7:0] i_data,
    input  logic       i_rs,
    input  logic       i_long_wait,
    output logic       o_done,
    output logic [7:0] o_lcd_data,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_en
);

    localparam int MAX_A   = (EN_CYCLES > CMD_WAIT_CYCLES) ? EN_CYCLES : CMD_WAIT_CYCLES;
    localparam int MAX_DLY = (MAX_A > CLR_WAIT_CYCLES) ? MAX_A : CLR_WAIT_CYCLES;
    localparam int CW      = $clog2(MAX_DLY + 1);

    localparam logic [CW-1:0] EN_LAST  = CW'(EN_CYCLES - 1);
    localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WAIT_CYCLES - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_WAIT_CYCLES - 1);

    bus_phase_e    phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    data_q, data_d;
    logic          rs_q, rs_d;
    logic          long_q, long_d;
    logic [CW-1:0] wait_last;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            phase_q <= B_IDLE;
            cnt_q   <= '0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            long_q  <= long_d;
        end
    end

    always_comb begin
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        rs_d      = rs_q;
        long_d    = long_q;
        o_done    = 1'b0;
        wait_last = long_q ? CLR_LAST : CMD_LAST;
        case (phase_q)
            B_IDLE: begin
                if (i_start) begin
                    phase_d = B_SETUP;
                    data_d  = i_data;
                    rs_d    = i_rs;
                    long_d  = i_long_wait;
                end
            end
            B_SETUP: begin
                phase_d = B_EN;
                cnt_d   = '0;
            end
            B_EN: begin
                if (cnt_q == EN_LAST) begin
                    phase_d = B_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            B_WAIT: begin
                if (cnt_q == wait_last) begin
                    o_done = 1'b1;
                    // A start in the done cycle chains directly into the next setup.
                    if (i_start) begin
                        phase_d = B_SETUP;
                        data_d  = i_data;
                        rs_d    = i_rs;
                        long_d  = i_long_wait;
                    end else begin
                        phase_d = B_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: phase_d = B_IDLE;
        endcase
    end

    // EN decodes straight from the phase register so reset drops it at once.
    assign o_lcd_en   = (phase_q == B_EN);
    assign o_lcd_data = data_q;
    assign o_lcd_rs   = rs_q;
    assign o_lcd_rw   = 1'b0;

endmodule

// File: rtl/lcd_text_engine.sv
// lcd_text_engine: HD44780-class ROWS x COLS character-LCD driver with a
// host-writable character buffer. After reset it waits POWERON_CYCLES, runs
// the init sequence once, then repaints only the rows marked dirty.
// Ports:
//   iCLK, iRST_N                 clock, asynchronous active-low reset
//   i_wr_en/row/col/char         buffer write, one character per cycle
//   i_clear                      fill buffer with spaces, mark all rows dirty
//   o_wr_err                     one-cycle pulse after an out-of-range write
//   o_ready                      init done and nothing dirty or in flight
//   o_lcd_data/rs/rw/en/on/blon  LCD pins
//   o_state_dbg                  current sequencer state
module lcd_text_engine
    import lcd_pkg::*;
#(
    parameter int COLS            = 16,
    parameter int ROWS            = 2,
    parameter int POWERON_CYCLES  = 750000,
    parameter int EN_CYCLES       = 25,
    parameter int CMD_WAIT_CYCLES = 2500,
    parameter int CLR_WAIT_CYCLES = 100000
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       i_wr_en,
    input  logic       i_wr_row,
    input  logic [5:0] i_wr_col,
    input  logic [7:0] i_wr_char,
    input  logic       i_clear,
    output logic       o_wr_err,
    output logic       o_ready,
    output logic [7:0] o_lcd_data,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_en,
    output logic       o_lcd_on,
    output logic       o_lcd_blon,
    output lcd_state_e o_state_dbg
);

    localparam int PW  = $clog2(POWERON_CYCLES + 1);
    localparam int CIW = $clog2(COLS);
    localparam logic [PW-1:0] PWR_LAST = PW'(POWERON_CYCLES - 1);
    localparam logic [5:0]    COL_LAST = 6'(COLS - 1);

    lcd_state_e    state_q, state_d;
    logic [PW-1:0] pwr_cnt_q, pwr_cnt_d;
    logic [1:0]    init_idx_q, init_idx_d;
    logic          row_q, row_d;
    logic [5:0]    col_q, col_d;
    logic          busy_q, busy_d;
    logic [ROWS-1:0] dirty_q, dirty_d;
    logic [ROWS-1:0] set_mask, clr_mask;
    logic [7:0]    buf_q [ROWS][COLS];
    logic          ready_q, ready_d;
    logic          wr_err_q, wr_err_d;

    logic          in_range, wr_take, go_idle;
    int            pick;
    logic          bus_start, bus_rs, bus_long, bus_done;
    logic [7:0]    bus_data;

    assign in_range = (int'(i_wr_row) < ROWS) && (int'(i_wr_col) < COLS);
    assign wr_take  = i_wr_en && in_range && !i_clear;
    assign wr_err_d = i_wr_en && !in_range;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= S_PWR;
            pwr_cnt_q  <= '0;
            init_idx_q <= 2'd0;
            row_q      <= 1'b0;
            col_q      <= 6'd0;
            busy_q     <= 1'b0;
            dirty_q    <= '1;
            ready_q    <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pwr_cnt_q  <= pwr_cnt_d;
            init_idx_q <= init_idx_d;
            row_q      <= row_d;
            col_q      <= col_d;
            busy_q     <= busy_d;
            dirty_q    <= dirty_d;
            ready_q    <= ready_d;
            wr_err_q   <= wr_err_d;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    buf_q[r][c] <= 8'h20;
        end else if (i_clear) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    buf_q[r][c] <= 8'h20;
        end else if (wr_take) begin
            buf_q[i_wr_row][i_wr_col[CIW-1:0]] <= i_wr_char;
        end
    end

    // Lowest-numbered dirty row.
    always_comb begin
        pick = 0;
        for (int r = ROWS - 1; r >= 0; r--)
            if (dirty_q[r]) pick = r;
    end

    always_comb begin
        state_d    = state_q;
        pwr_cnt_d  = pwr_cnt_q;
        init_idx_d = init_idx_q;
        row_d      = row_q;
        col_d      = col_q;
        go_idle    = 1'b0;
        clr_mask   = '0;
        case (state_q)
            S_PWR: begin
                if (pwr_cnt_q == PWR_LAST) begin
                    state_d    = S_INIT;
                    pwr_cnt_d  = '0;
                    init_idx_d = 2'd0;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + PW'(1);
                end
            end
            S_INIT: begin
                if (bus_done) begin
                    if (init_idx_q == 2'd3) go_idle = 1'b1;
                    else                    init_idx_d = init_idx_q + 2'd1;
                end
            end
            S_IDLE: go_idle = 1'b1;
            S_ADDR: begin
                if (bus_done) begin
                    state_d = S_CHAR;
                    col_d   = 6'd0;
                end
            end
            S_CHAR: begin
                if (bus_done) begin
                    if (col_q == COL_LAST) begin
                        go_idle = 1'b1;
                        col_d   = 6'd0;
                    end else begin
                        col_d = col_q + 6'd1;
                    end
                end
            end
            default: state_d = S_PWR;
        endcase
        // Landing in idle with a dirty row picks it in the same cycle, so the
        // next row's address command follows without an extra bus gap.
        if (go_idle) begin
            state_d = S_IDLE;
            if (|dirty_q) begin
                state_d = S_ADDR;
                row_d   = 1'(pick);
                for (int r = 0; r < ROWS; r++)
                    clr_mask[r] = (r == pick);
            end
        end
    end

    // Set wins over the idle-time clear; i_clear re-dirties every row.
    always_comb begin
        for (int r = 0; r < ROWS; r++)
            set_mask[r] = wr_take && (int'(i_wr_row) == r);
        dirty_d = i_clear ? '1 : ((dirty_q & ~clr_mask) | set_mask);
        ready_d = (state_d == S_IDLE) && (dirty_d == '0) && !i_clear;
    end

    // Requests are issued from the next-state view so each transaction starts
    // in the cycle the previous one reports done.
    always_comb begin
        bus_start = 1'b0;
        bus_data  = 8'h00;
        bus_rs    = 1'b0;
        bus_long  = 1'b0;
        if (!busy_q || bus_done) begin
            case (state_d)
                S_INIT: begin
                    bus_start = 1'b1;
                    bus_data  = init_cmd(init_idx_d);
                    bus_long  = (init_idx_d == 2'd2);
                end
                S_ADDR: begin
                    bus_start = 1'b1;
                    bus_data  = LCD_SET_DDRAM | (row_d ? LCD_ROW1_BASE : LCD_ROW0_BASE);
                end
                S_CHAR: begin
                    bus_start = 1'b1;
                    bus_rs    = 1'b1;
                    bus_data  = buf_q[row_d][col_d[CIW-1:0]];
                end
                default: bus_start = 1'b0;
            endcase
        end
        busy_d = bus_start ? 1'b1 : (bus_done ? 1'b0 : busy_q);
    end

    lcd_bus_writer #(
        .EN_CYCLES      (EN_CYCLES),
        .CMD_WAIT_CYCLES(CMD_WAIT_CYCLES),
        .CLR_WAIT_CYCLES(CLR_WAIT_CYCLES)
    ) u_bus (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .i_start    (bus_start),
        .i_data     (bus_data),
        .i_rs       (bus_rs),
        .i_long_wait(bus_long),
        .o_done     (bus_done),
        .o_lcd_data (o_lcd_data),
        .o_lcd_rs   (o_lcd_rs),
        .o_lcd_rw   (o_lcd_rw),
        .o_lcd_en   (o_lcd_en)
    );

    assign o_ready     = ready_q;
    assign o_wr_err    = wr_err_q;
    assign o_lcd_on    = 1'b1;
    assign o_lcd_blon  = 1'b1;
    assign o_state_dbg = state_q;

endmodule

// File: tb/tb_lcd_text_engine.sv
// Bench for lcd_text_engine with small timing parameters. A bus monitor
// records every EN pulse as {rs,data}, the EN-low gaps, and drives a model
// HD44780 DDRAM; scenarios compare against streams built from a model buffer.
module tb_lcd_text_engine;
    import lcd_pkg::*;

    localparam int COLS = 16;
    localparam int ROWS = 2;
    localparam int PWR  = 20;
    localparam int ENC  = 2;
    localparam int CMDW = 4;
    localparam int CLRW = 10;
    localparam int BOOT_TX = 4 + ROWS * (COLS + 1);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic       wr_row = 1'b0;
    logic [5:0] wr_col = 6'd0;
    logic [7:0] wr_char = 8'h00;
    logic       clr = 1'b0;
    logic       wr_err, ready, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon;
    logic [7:0] lcd_data;
    lcd_state_e st_dbg;

    always #5 clk = ~clk;

    lcd_text_engine #(
        .COLS(COLS), .ROWS(ROWS), .POWERON_CYCLES(PWR), .EN_CYCLES(ENC),
        .CMD_WAIT_CYCLES(CMDW), .CLR_WAIT_CYCLES(CLRW)
    ) dut (
        .iCLK(clk), .iRST_N(rst_n), .i_wr_en(wr_en), .i_wr_row(wr_row),
        .i_wr_col(wr_col), .i_wr_char(wr_char), .i_clear(clr),
        .o_wr_err(wr_err), .o_ready(ready), .o_lcd_data(lcd_data),
        .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw), .o_lcd_en(lcd_en),
        .o_lcd_on(lcd_on), .o_lcd_blon(lcd_blon), .o_state_dbg(st_dbg)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- bus monitor and model display ----------------
    logic [8:0] cap_q[$];
    int         gap_q[$];
    int         cyc, first_rise, low_run, err_pulses = 0;
    logic       en_prev;
    logic [7:0] lcd_mem [128];
    logic [6:0] lcd_addr;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            cyc = 0; first_rise = 0; low_run = 0; en_prev = 1'b0; lcd_addr = 7'd0;
            for (int i = 0; i < 128; i++) lcd_mem[i] = 8'h00;
        end else begin
            cyc++;
            if (wr_err) err_pulses++;
            if (lcd_en && !en_prev) begin
                if (first_rise == 0) first_rise = cyc;
                else gap_q.push_back(low_run - 1);
                low_run = 0;
                cap_q.push_back({lcd_rs, lcd_data});
                if (lcd_rs) begin
                    lcd_mem[lcd_addr] = lcd_data;
                    lcd_addr = lcd_addr + 7'd1;
                end else if (lcd_data[7]) begin
                    lcd_addr = lcd_data[6:0];
                end else if (lcd_data == 8'h01) begin
                    for (int i = 0; i < 128; i++) lcd_mem[i] = 8'h20;
                    lcd_addr = 7'd0;
                end
            end else if (!lcd_en) begin
                low_run++;
            end
            en_prev = lcd_en;
        end
    end

    // ---------------- reference model and scoreboard ----------------
    logic [7:0] mbuf [ROWS][COLS];
    logic [8:0] exp_q[$];

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) mbuf[r][c] = 8'h20;
    endtask

    task automatic exp_init();
        exp_q.push_back({1'b0, 8'h38}); exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01}); exp_q.push_back({1'b0, 8'h06});
    endtask

    task automatic exp_row(input int r);
        exp_q.push_back({1'b0, 8'h80 + 8'(r * 64)});
        for (int c = 0; c < COLS; c++) exp_q.push_back({1'b1, mbuf[r][c]});
    endtask

    task automatic compare_stream(input string tag, input int base);
        int got_n;
        got_n = cap_q.size() - base;
        check_val({tag, "_len"}, got_n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_n; i++)
            check_val($sformatf("%s_tx%0d", tag, i), cap_q[base + i], exp_q[i]);
        exp_q.delete();
    endtask

    task automatic check_display(input string tag);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                check_val($sformatf("%s_r%0dc%0d", tag, r, c), lcd_mem[r * 64 + c], mbuf[r][c]);
    endtask

    // ---------------- drivers ----------------
    task automatic do_write(input logic row, input logic [5:0] col, input logic [7:0] ch,
                            input logic with_clear, output logic err_seen);
        @(negedge clk);
        wr_en = 1'b1; wr_row = row; wr_col = col; wr_char = ch; clr = with_clear;
        @(negedge clk);
        err_seen = wr_err;
        wr_en = 1'b0; clr = 1'b0;
        if (with_clear) model_clear();
        else if (col < COLS) mbuf[row][col] = ch;
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n = 0;
        while (!ready && n < budget) begin @(negedge clk); n++; end
        check_val(tag, ready, 1'b1);
    endtask

    task automatic wait_caps(input string tag, input int target, input int budget);
        int n = 0;
        while (cap_q.size() < target && n < budget) begin @(negedge clk); n++; end
        check_val(tag, (cap_q.size() >= target), 1'b1);
    endtask

    task automatic boot_check(input string tag);
        int base, gbase, ng;
        base = cap_q.size();
        gbase = gap_q.size();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val({tag, "_ready_low"}, ready, 1'b0);
        wait_ready({tag, "_ready"}, 3000);
        check_val({tag, "_tx_at_ready"}, cap_q.size() - base, BOOT_TX);
        check_val({tag, "_first_en"}, first_rise, PWR + 1);
        exp_init(); exp_row(0); exp_row(1);
        compare_stream({tag, "_stream"}, base);
        ng = gap_q.size() - gbase;
        check_val({tag, "_gap_n"}, ng, BOOT_TX - 1);
        for (int i = 0; i < ng; i++)
            check_val($sformatf("%s_gap%0d", tag, i), gap_q[gbase + i], (i == 2) ? CLRW : CMDW);
        check_display({tag, "_disp"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, e0, nw, inv, n_31, n;
        logic err, any_low, row;
        logic [5:0] col;

        model_clear();
        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_data", lcd_data, 8'h00);
        check_val("rst_rs", lcd_rs, 1'b0);
        check_val("rst_rw", lcd_rw, 1'b0);
        check_val("rst_en", lcd_en, 1'b0);
        check_val("rst_ready", ready, 1'b0);
        check_val("rst_wr_err", wr_err, 1'b0);
        check_val("rst_on", lcd_on, 1'b1);
        check_val("rst_blon", lcd_blon, 1'b1);
        check_val("rst_state", st_dbg, S_PWR);

        // 1: power-on, init, full paint
        boot_check("boot");

        // 2: single write refreshes only row 1
        base = cap_q.size();
        do_write(1'b1, 6'd3, 8'h41, 1'b0, err);
        check_val("s2_no_err", err, 1'b0);
        check_val("s2_ready_drop", ready, 1'b0);
        wait_ready("s2_ready", 2000);
        exp_row(1);
        compare_stream("s2", base);

        // 3: out-of-range writes
        base = cap_q.size();
        e0 = err_pulses;
        do_write(1'b1, 6'd16, 8'h42, 1'b0, err);
        check_val("s3_err_a", err, 1'b1);
        do_write(1'b0, 6'd63, 8'h42, 1'b0, err);
        check_val("s3_err_b", err, 1'b1);
        any_low = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (!ready) any_low = 1'b1;
        end
        check_val("s3_ready_stays", any_low, 1'b0);
        check_val("s3_err_pulses", err_pulses - e0, 2);
        check_val("s3_no_bus", cap_q.size() - base, 0);
        check_display("s3_disp");

        // 4: write to row 0 while its character 4 is on the bus
        base = cap_q.size();
        do_write(1'b0, 6'd5, 8'h33, 1'b0, err);
        wait_caps("s4_reach_c4", base + 6, 500);
        do_write(1'b0, 6'd15, 8'h5A, 1'b0, err);
        wait_ready("s4_ready", 2000);
        check_val("s4_tx_at_ready", cap_q.size() - base, 2 * (COLS + 1));
        exp_row(0); exp_row(0);
        compare_stream("s4", base);

        // 5: clear with a simultaneous write
        base = cap_q.size();
        do_write(1'b0, 6'd0, 8'h31, 1'b1, err);
        wait_ready("s5_ready", 2000);
        n_31 = 0;
        for (int i = base; i < cap_q.size(); i++)
            if (cap_q[i] == {1'b1, 8'h31}) n_31++;
        check_val("s5_no_31", n_31, 0);
        exp_row(0); exp_row(1);
        compare_stream("s5", base);
        check_display("s5_disp");

        // Randomized bursts of back-to-back writes
        for (int it = 0; it < 6; it++) begin
            nw = $urandom_range(1, 5);
            inv = 0;
            e0 = err_pulses;
            for (int k = 0; k < nw; k++) begin
                row = 1'($urandom_range(0, 1));
                col = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(16, 63)) : 6'($urandom_range(0, 15));
                @(negedge clk);
                wr_en = 1'b1; wr_row = row; wr_col = col; wr_char = 8'($urandom_range(8'h21, 8'h7E));
                if (col < COLS) mbuf[row][col] = wr_char;
                else inv++;
            end
            @(negedge clk);
            wr_en = 1'b0;
            if (inv != nw) wait_ready($sformatf("rnd%0d_ready", it), 3000);
            n = 0;
            while (!ready && n < 3000) begin @(negedge clk); n++; end
            @(negedge clk);
            check_val($sformatf("rnd%0d_err", it), err_pulses - e0, inv);
            check_display($sformatf("rnd%0d_disp", it));
        end

        // 6: asynchronous reset while EN is high during a row paint
        do_write(1'b0, 6'd0, 8'h52, 1'b0, err);
        n = 0;
        while (!(st_dbg == S_CHAR && lcd_en) && n < 500) begin @(negedge clk); n++; end
        check_val("s6_in_char_en", (st_dbg == S_CHAR && lcd_en), 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("s6_en_async", lcd_en, 1'b0);
        check_val("s6_state_async", st_dbg, S_PWR);
        model_clear();
        repeat (3) @(negedge clk);
        boot_check("reboot");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
